// File: rtl/booth_operand_sequencer.sv
// Buffers signed operand pairs, loads them into the Booth core (multiplicand, then multiplier), and returns the product MUL_LATENCY+3 cycles after pop.
// in_ready = FIFO not full (or popping); a held out_valid blocks new starts. Optional ZERO_BYPASS_EN: zero operand skips the core.
module booth_operand_sequencer #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int MUL_LATENCY = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_mcand,
    input  logic [DATA_W-1:0]     in_mplier,
    output logic [DATA_W-1:0]     mul_data,
    output logic                  mul_start,
    input  logic [2*DATA_W-1:0]   mul_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_product,
    output logic                  busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(MUL_LATENCY);

    typedef struct packed {
        logic [DATA_W-1:0] mcand;
        logic [DATA_W-1:0] mplier;
    } pair_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_M,
        ST_LOAD_Q,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    pair_t             mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [LW-1:0]     wait_cnt;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              skip_core;

    assign fifo_empty = (count == '0);
    // A product accepted this cycle frees IDLE to pop immediately, giving one op per MUL_LATENCY+3 cycles.
    assign pop      = (state == ST_IDLE) && !fifo_empty && (!out_valid || out_ready);
    assign in_ready = (count != CW'(FIFO_DEPTH)) || pop;
    assign push     = in_valid && in_ready;

`ifdef ZERO_BYPASS_EN
    logic zero_q;
    assign skip_core = (mem[rd_ptr].mcand == '0) || (mem[rd_ptr].mplier == '0);
`else
    assign skip_core = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{mcand: in_mcand, mplier: in_mplier};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                mcand_q  <= mem[rd_ptr].mcand;
                mplier_q <= mem[rd_ptr].mplier;
            end
            if (state == ST_LOAD_Q) begin
                wait_cnt <= LW'(MUL_LATENCY - 1);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - LW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mul_data  = '0;
        mul_start = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (pop) begin
                    state_nxt = skip_core ? ST_CAPTURE : ST_LOAD_M;
                end
            end
            ST_LOAD_M: begin
                mul_data  = mcand_q;
                mul_start = 1'b1;
                state_nxt = ST_LOAD_Q;
            end
            ST_LOAD_Q: begin
                mul_data  = mplier_q;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                mul_data = mplier_q;
                // Counter reaches zero on the same edge that enters CAPTURE.
                if (wait_cnt == LW'(1)) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef ZERO_BYPASS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_q <= 1'b0;
        end else if (pop) begin
            zero_q <= skip_core;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_product <= '0;
        end else if (state == ST_CAPTURE) begin
            out_valid <= 1'b1;
`ifdef ZERO_BYPASS_EN
            out_product <= zero_q ? '0 : mul_result;
`else
            out_product <= mul_result;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Scoreboard bench for booth_operand_sequencer with a behavioural Booth-core stand-in.
// Stimulus pushes expected products; a negedge monitor checks loads, latency, hold and products.
module tb_booth_operand_sequencer;

    localparam int DATA_W      = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int MUL_LATENCY = 34;

    typedef struct {
        logic [31:0] prod;
        bit          byp;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } ld_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mcand;
    logic [15:0] in_mplier;
    logic [15:0] mul_data;
    logic        mul_start;
    logic [31:0] mul_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_product;
    logic        busy;

    exp_t exp_q[$];
    ld_t  ld_q[$];
    int   st_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 1;

    booth_operand_sequencer #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MUL_LATENCY(MUL_LATENCY)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mcand(in_mcand), .in_mplier(in_mplier), .mul_data(mul_data),
        .mul_start(mul_start), .mul_result(mul_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_product(out_product), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Core stand-in: multiplicand on the start cycle, multiplier next; product MUL_LATENCY cycles after that, noise before.
    int core_a = 0, core_b = 0, core_cnt = 0, core_ph = 0;
    always @(posedge clk) begin
        if (mul_start) begin
            core_a     <= int'($signed(mul_data));
            core_ph    <= 1;
            mul_result <= $urandom;
        end else if (core_ph == 1) begin
            core_b     <= int'($signed(mul_data));
            core_cnt   <= MUL_LATENCY - 1;
            core_ph    <= 2;
            mul_result <= $urandom;
        end else if (core_ph == 2) begin
            if (core_cnt == 1) begin
                mul_result <= 32'(core_a * core_b);
                core_ph    <= 3;
            end else begin
                core_cnt   <= core_cnt - 1;
                mul_result <= $urandom;
            end
        end
    end

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_prod = '0;
    bit          ld_pending = 0;
    exp_t        e;
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            ld_pending = 0;
            prev_valid = 1'b0;
        end else begin
            if (ld_pending) begin
                if (ld_q.size() > 0) begin
                    check("load_mplier", 32'(mul_data), 32'(ld_q[0].b));
                    void'(ld_q.pop_front());
                end
                check("start_single_pulse", 32'(mul_start), 32'd0);
                ld_pending = 0;
            end else if (mul_start) begin
                if (ld_q.size() == 0) begin
                    flag("unexpected_start");
                end else begin
                    check("load_mcand", 32'(mul_data), 32'(ld_q[0].a));
                    st_q.push_back(cyc);
                    ld_pending = 1;
                end
            end
            if (out_valid && !prev_valid && exp_q.size() > 0 && !exp_q[0].byp) begin
                if (st_q.size() == 0) flag("valid_without_start");
                else check("latency", 32'(cyc - st_q.pop_front()), 32'(MUL_LATENCY + 2));
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_product", out_product, prev_prod);
            end
            if (out_valid && !out_ready) begin
                check("stall_idle", 32'({busy, mul_start}), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_product");
                end else begin
                    e = exp_q.pop_front();
                    check("product", out_product, e.prod);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_prod  = out_product;
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int   t = 0;
        exp_t x;
        ld_t  l;
        @(negedge clk);
        in_valid  = 1'b1;
        in_mcand  = a;
        in_mplier = b;
        #1;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            flag("push_timeout");
        end else begin
            x.prod = 32'(int'($signed(a)) * int'($signed(b)));
`ifdef ZERO_BYPASS_EN
            x.byp = (a == 16'd0) || (b == 16'd0);
`else
            x.byp = 1'b0;
`endif
            exp_q.push_back(x);
            if (!x.byp) begin
                l.a = a;
                l.b = b;
                ld_q.push_back(l);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int t = 0;
        while (exp_q.size() != 0 && t < max) begin
            @(negedge clk);
            #4;
            t++;
        end
        if (exp_q.size() != 0) flag("drain_timeout");
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mul_data", 32'(mul_data), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_product", out_product, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int t;
        logic [15:0] a, b;
        clk = 1'b0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_mcand = '0;
        in_mplier = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;

        push(16'd3, 16'hFFF9);
        wait_drain(200);
        push(16'h8000, 16'h8000);
        push(16'h7FFF, 16'hFFFF);
        wait_drain(300);
        push(16'd0, 16'd1234);
        wait_drain(200);

        // Fill: one pair goes in flight, four more fill the FIFO.
        rdy_mode = 0;
        @(negedge clk);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) push(16'($urandom), 16'($urandom));
        check("fifo_full_ready", 32'(in_ready), 32'd0);
        t = 0;
        while (!out_valid && t < MUL_LATENCY + 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!out_valid) flag("fill_valid_timeout");
        repeat (100) @(negedge clk);
        #1;
        rdy_mode = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("restart_after_accept", 32'(mul_start), 32'd1);
        wait_drain(6 * (MUL_LATENCY + 5));

        // Reset while the core is computing.
        push(16'd11, 16'd13);
        t = 0;
        while (!mul_start && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!mul_start) flag("abort_start_timeout");
        repeat (10) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        ld_q.delete();
        st_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (MUL_LATENCY + 10) @(negedge clk);
        push(16'd5, 16'd6);
        wait_drain(200);

        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            push(a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(4000);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
